// File: rtl/of_stage_pipelined.sv
// Operand-fetch stage: decodes rs/rt/dest, reads two operands from an internal register file, registers the result.
// Latency: 1 cycle from accept to out_valid; no bubbles when a new accept coincides with a consume.
// Backpressure: in_ready = !out_valid || out_ready; a held entry's operands track write-backs while stalled.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   in_valid / in_ready             instruction handshake (instruction, reg_dst)
//   flush                           kill the output entry and drop this cycle's input
//   wb_we, wb_addr, wb_data         register-file write port from write-back
//   out_valid / out_ready           output handshake
//   out_rs_data, out_rt_data        fetched operands
//   out_rs, out_rt, out_dest        latched 5-bit indices (unmasked fields)
//   out_instr                       latched instruction word

module of_stage_pipelined #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instruction,
   input  logic            reg_dst,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_rs_data,
   output logic [XLEN-1:0] out_rt_data,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_dest,
   output logic [31:0]     out_instr
);

   // Register index width; only the low IW bits of each 5-bit field select a register.
   localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

   typedef logic [IW-1:0] idx_t;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [4:0] rs_f;
   logic [4:0] rt_f;
   logic [4:0] rd_f;
   logic [4:0] dest_f;

   assign rs_f   = instruction[25:21];
   assign rt_f   = instruction[20:16];
   assign rd_f   = instruction[15:11];
   // Destination is left unmasked for r0; execute/write-back decide what to do with it.
   assign dest_f = reg_dst ? rd_f : rt_f;

   idx_t rs_idx;
   idx_t rt_idx;
   idx_t wb_idx;

   assign rs_idx = rs_f[IW-1:0];
   assign rt_idx = rt_f[IW-1:0];
   assign wb_idx = wb_addr[IW-1:0];

   // A write is "effective" only if it really changes architectural state.
   // With R0_ZERO the r0 write is swallowed here, which also keeps it out of
   // the bypass and the stall-refresh paths below.
   logic wb_eff;
   assign wb_eff = wb_we && ((wb_idx != '0) || !R0_ZERO);

   // ------------------------------------------------------------------
   // Register file: one synchronous write port, two combinational reads
   // ------------------------------------------------------------------
   logic [XLEN-1:0] rf_q [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_eff) begin
         rf_q[wb_idx] <= wb_data;
      end
   end

   // Read with r0 forcing and same-cycle write-back bypass.
   function automatic logic [XLEN-1:0] read_port(
      input idx_t            idx,
      input logic [XLEN-1:0] rf_val,
      input logic            weff,
      input idx_t            widx,
      input logic [XLEN-1:0] wdat
   );
      logic [XLEN-1:0] val;
      if (R0_ZERO && (idx == '0)) begin
         val = '0;
      end else if (weff && (widx == idx)) begin
         val = wdat;
      end else begin
         val = rf_val;
      end
      return val;
   endfunction

   logic [XLEN-1:0] rs_rd;
   logic [XLEN-1:0] rt_rd;

   assign rs_rd = read_port(rs_idx, rf_q[rs_idx], wb_eff, wb_idx, wb_data);
   assign rt_rd = read_port(rt_idx, rf_q[rt_idx], wb_eff, wb_idx, wb_data);

   // ------------------------------------------------------------------
   // Output pipeline register
   // ------------------------------------------------------------------
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] rs_data_q,   rs_data_d;
   logic [XLEN-1:0] rt_data_q,   rt_data_d;
   logic [4:0]      rs_q,        rs_d;
   logic [4:0]      rt_q,        rt_d;
   logic [4:0]      dest_q,      dest_d;
   logic [31:0]     instr_q,     instr_d;

   logic accept;
   logic hold;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   // A stalled entry stays put; its operands must follow any write to its sources.
   assign hold     = out_valid_q && !out_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      rs_data_d   = rs_data_q;
      rt_data_d   = rt_data_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      dest_d      = dest_q;
      instr_d     = instr_q;

      // Flush beats accept and hold; an un-replaced consume empties the slot.
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         rs_data_d = rs_rd;
         rt_data_d = rt_rd;
         rs_d      = rs_f;
         rt_d      = rt_f;
         dest_d    = dest_f;
         instr_d   = instruction;
      end else if (hold && wb_eff) begin
         // Compare on the aliased index, same as the register file sees it.
         if (rs_q[IW-1:0] == wb_idx) begin
            rs_data_d = wb_data;
         end
         if (rt_q[IW-1:0] == wb_idx) begin
            rt_data_d = wb_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         dest_q      <= '0;
         instr_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         rs_data_q   <= rs_data_d;
         rt_data_q   <= rt_data_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         dest_q      <= dest_d;
         instr_q     <= instr_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_rs_data = rs_data_q;
   assign out_rt_data = rt_data_q;
   assign out_rs      = rs_q;
   assign out_rt      = rt_q;
   assign out_dest    = dest_q;
   assign out_instr   = instr_q;

endmodule

// File: tb/tb_of_stage_pipelined.sv
// Bench for of_stage_pipelined: two instances share stimulus
// (u_a: NREGS=32, R0_ZERO=1; u_b: NREGS=8, R0_ZERO=0).
// A behavioural model runs per instance; literal checks pin the model.

module tb_of_stage_pipelined;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] instruction = '0;
   logic        reg_dst = 1'b0;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        out_ready = 1'b1;

   logic        a_in_ready, a_out_valid;
   logic [31:0] a_rsd, a_rtd, a_ins;
   logic [4:0]  a_rs, a_rt, a_dst;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_rsd, b_rtd, b_ins;
   logic [4:0]  b_rs, b_rt, b_dst;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   of_stage_pipelined #(.XLEN(32), .NREGS(32), .R0_ZERO(1'b1)) u_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
      .instruction(instruction), .reg_dst(reg_dst), .flush(flush),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(a_out_valid), .out_ready(out_ready),
      .out_rs_data(a_rsd), .out_rt_data(a_rtd), .out_rs(a_rs), .out_rt(a_rt),
      .out_dest(a_dst), .out_instr(a_ins)
   );

   of_stage_pipelined #(.XLEN(32), .NREGS(8), .R0_ZERO(1'b0)) u_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
      .instruction(instruction), .reg_dst(reg_dst), .flush(flush),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_rs_data(b_rsd), .out_rt_data(b_rtd), .out_rs(b_rs), .out_rt(b_rt),
      .out_dest(b_dst), .out_instr(b_ins)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model (index 0 -> u_a, 1 -> u_b)
   // ------------------------------------------------------------------
   logic [31:0] m_rf  [2][32];
   logic        m_vld [2];
   logic [31:0] m_rsd [2];
   logic [31:0] m_rtd [2];
   logic [31:0] m_ins [2];
   logic [4:0]  m_rs  [2];
   logic [4:0]  m_rt  [2];
   logic [4:0]  m_dst [2];

   function automatic logic [4:0] msk(input int k, input logic [4:0] f);
      return (k == 0) ? f : (f & 5'd7);
   endfunction

   function automatic bit r0z(input int k);
      return (k == 0);
   endfunction

   task automatic m_clear();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) m_rf[k][i] = '0;
         m_vld[k] = 1'b0; m_rsd[k] = '0; m_rtd[k] = '0; m_ins[k] = '0;
         m_rs[k] = '0; m_rt[k] = '0; m_dst[k] = '0;
      end
   endtask

   function automatic logic [31:0] m_read(input int k, input logic [4:0] f);
      logic [4:0] i;
      logic [4:0] w;
      i = msk(k, f);
      w = msk(k, wb_addr);
      if (r0z(k) && i == 5'd0) return 32'd0;
      if (wb_we && (w != 5'd0 || !r0z(k)) && w == i) return wb_data;
      return m_rf[k][i];
   endfunction

   task automatic m_step(input int k);
      logic [4:0] w;
      bit weff, acc;
      w    = msk(k, wb_addr);
      weff = wb_we && (w != 5'd0 || !r0z(k));
      acc  = in_valid && (!m_vld[k] || out_ready) && !flush;
      if (acc) begin
         m_rsd[k] = m_read(k, instruction[25:21]);
         m_rtd[k] = m_read(k, instruction[20:16]);
         m_rs[k]  = instruction[25:21];
         m_rt[k]  = instruction[20:16];
         m_dst[k] = reg_dst ? instruction[15:11] : instruction[20:16];
         m_ins[k] = instruction;
      end else if (m_vld[k] && !out_ready && weff) begin
         if (msk(k, m_rs[k]) == w) m_rsd[k] = wb_data;
         if (msk(k, m_rt[k]) == w) m_rtd[k] = wb_data;
      end
      if (flush)          m_vld[k] = 1'b0;
      else if (acc)       m_vld[k] = 1'b1;
      else if (out_ready) m_vld[k] = 1'b0;
      if (weff) m_rf[k][w] = wb_data;
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         m_step(0);
         m_step(1);
      end
   end

   task automatic cmp(input int k, input logic rdy, input logic vld,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input logic [31:0] ins);
      string p;
      p = (k == 0) ? "a." : "b.";
      chk({p, "in_ready"}, 32'(rdy), 32'(!m_vld[k] || out_ready));
      chk({p, "out_valid"}, 32'(vld), 32'(m_vld[k]));
      if (m_vld[k]) begin
         chk({p, "out_rs_data"}, rsd, m_rsd[k]);
         chk({p, "out_rt_data"}, rtd, m_rtd[k]);
         chk({p, "out_rs"}, 32'(rs), 32'(m_rs[k]));
         chk({p, "out_rt"}, 32'(rt), 32'(m_rt[k]));
         chk({p, "out_dest"}, 32'(dst), 32'(m_dst[k]));
         chk({p, "out_instr"}, ins, m_ins[k]);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         cmp(0, a_in_ready, a_out_valid, a_rsd, a_rtd, a_rs, a_rt, a_dst, a_ins);
         cmp(1, b_in_ready, b_out_valid, b_rsd, b_rtd, b_rs, b_rt, b_dst, b_ins);
      end
   end

   // ------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------
   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'b0, rs, rt, rd, 11'b0};
   endfunction

   task automatic drv(input logic iv, input logic [31:0] ins, input logic rdst,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic ordy);
      in_valid = iv; instruction = ins; reg_dst = rdst; flush = fl;
      wb_we = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
   endtask

   task automatic idle();
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] held_ins;
   logic [31:0] pend_ins;

   initial begin
      m_clear();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      chk("oor a.in_ready", 32'(a_in_ready), 32'd1);
      chk("oor a.out_valid", 32'(a_out_valid), 32'd0);
      chk("oor b.out_valid", 32'(b_out_valid), 32'd0);

      // Fill r3 and the output register, then reset mid-cycle.
      drv(1'b1, mk(5'd1, 5'd1, 5'd1), 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000AAAA, 1'b1);
      step();
      chk("pre-reset a.out_valid", 32'(a_out_valid), 32'd1);
      idle();
      #2 reset = 1'b1;
      m_clear();
      #1;
      chk("rst a.out_valid", 32'(a_out_valid), 32'd0);
      chk("rst a.out_rs_data", a_rsd, 32'd0);
      chk("rst a.out_rt_data", a_rtd, 32'd0);
      chk("rst a.out_dest", 32'(a_dst), 32'd0);
      chk("rst a.out_instr", a_ins, 32'd0);
      chk("rst b.out_valid", 32'(b_out_valid), 32'd0);
      reset = 1'b0;
      drv(1'b1, mk(5'd3, 5'd4, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      step();
      chk("post-rst a.out_valid", 32'(a_out_valid), 32'd1);
      chk("post-rst a.rs_data r3", a_rsd, 32'd0);
      chk("post-rst a.rt_data r4", a_rtd, 32'd0);

      // Write then read; same-edge bypass.
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
      step();
      drv(1'b1, mk(5'd5, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      step();
      chk("rd a.rs_data r5", a_rsd, 32'hDEADBEEF);
      chk("rd b.rs_data r5", b_rsd, 32'hDEADBEEF);
      drv(1'b1, mk(5'd7, 5'd7, 5'd0), 1'b0, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1);
      step();
      chk("byp a.rs_data r7", a_rsd, 32'h12345678);
      chk("byp a.rt_data r7", a_rtd, 32'h12345678);
      chk("byp b.rt_data r7", b_rtd, 32'h12345678);

      // r0 write: ignored with R0_ZERO=1, ordinary with R0_ZERO=0.
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
      step();
      drv(1'b1, mk(5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      step();
      chk("r0 a.rs_data", a_rsd, 32'd0);
      chk("r0 b.rs_data", b_rsd, 32'hFFFFFFFF);

      // Stall with refresh of a held operand.
      held_ins = mk(5'd2, 5'd3, 5'd0);
      pend_ins = mk(5'd9, 5'd9, 5'd9);
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2, 32'h00000011, 1'b1);
      step();
      drv(1'b1, held_ins, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      step();
      chk("stall a.rs_data r2", a_rsd, 32'h00000011);
      drv(1'b1, pend_ins, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1 chk("stall1 a.in_ready", 32'(a_in_ready), 32'd0);
      step();
      chk("stall1 a.out_instr", a_ins, held_ins);
      drv(1'b1, pend_ins, 1'b1, 1'b0, 1'b1, 5'd2, 32'h00000022, 1'b0);
      #1 chk("stall2 a.in_ready", 32'(a_in_ready), 32'd0);
      step();
      chk("refresh a.rs_data", a_rsd, 32'h00000022);
      chk("refresh b.rs_data", b_rsd, 32'h00000022);
      drv(1'b1, pend_ins, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1 chk("stall3 a.in_ready", 32'(a_in_ready), 32'd0);
      step();
      chk("stall3 a.out_instr", a_ins, held_ins);
      out_ready = 1'b1;
      #1 chk("release a.in_ready", 32'(a_in_ready), 32'd1);
      step();
      chk("release a.out_instr", a_ins, pend_ins);
      chk("release a.out_valid", 32'(a_out_valid), 32'd1);

      // Flush drops the input but the write-back still lands.
      drv(1'b1, mk(5'd6, 5'd6, 5'd6), 1'b0, 1'b1, 1'b1, 5'd6, 32'h00000066, 1'b0);
      step();
      chk("flush a.out_valid", 32'(a_out_valid), 32'd0);
      chk("flush b.out_valid", 32'(b_out_valid), 32'd0);
      drv(1'b1, mk(5'd6, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      step();
      chk("flush wb a.rs_data r6", a_rsd, 32'h00000066);
      chk("flush wb b.rs_data r6", b_rsd, 32'h00000066);

      // Full-throughput stream with alternating reg_dst.
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, mk(5'd1, 5'd9, 5'd10), i[0], 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
         step();
         chk("stream a.out_valid", 32'(a_out_valid), 32'd1);
         chk("stream a.out_dest", 32'(a_dst), i[0] ? 32'd10 : 32'd9);
      end
      idle();
      step();
      chk("drain a.out_valid", 32'(a_out_valid), 32'd0);

      // Index aliasing: with NREGS=8, r12 is r4.
      drv(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h00001234, 1'b1);
      step();
      drv(1'b1, mk(5'd4, 5'd12, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      step();
      chk("alias a.rs_data r4", a_rsd, 32'd0);
      chk("alias a.rt_data r12", a_rtd, 32'h00001234);
      chk("alias b.rs_data r4", b_rsd, 32'h00001234);
      chk("alias b.rt_data r12", b_rtd, 32'h00001234);
      chk("alias b.out_rt field", 32'(b_rt), 32'd12);

      idle();
      step();
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
